p32_id_ex_stage: RTL and testbench
==================================

// Module: p32_id_ex_stage
// PURPOSE
//  ID/EX pipeline register and stall/flush control for the p32 pipeline. Latches
//  decoded ID instructions and their forwarded operands into EX.
//  Converts the forwarding unit's load_hazard into a one-cycle bubble plus an
//  upstream stall. Honours downstream stall and branch flush.
//  Drives the EX-stage strobe/address/load flag back to the forwarding unit.
// PARAMETERS
//  XLEN   32  datapath width
//  OPW    4   ALU op code width
//  CNT_W  16  width of saturating bubble counter
// PORTS
//  m_clock      in   1     clock, all state on rising edge
//  p_reset      in   1     synchronous reset, active-high
//  id_valid     in   1     ID holds a valid instruction
//  id_pc        in   XLEN  PC of ID instruction
//  id_rs1_val   in   XLEN  forwarded operand 1 (forwarding set1_out)
//  id_rs2_val   in   XLEN  forwarded operand 2 (forwarding set2_out)
//  id_imm       in   XLEN  sign-extended immediate
//  id_use_imm   in   1     ALU operand B = imm instead of rs2
//  id_rd        in   5     destination register
//  id_wen       in   1     instruction writes rd
//  id_load      in   1     instruction is a load
//  id_store     in   1     instruction is a store
//  id_alu_op    in   OPW   ALU operation
//  load_hazard  in   1     load-use hazard from forwarding unit
//  ex_stall     in   1     EX/MEM cannot accept (multicycle op)
//  flush        in   1     branch taken/redirect: kill ID->EX transfer
//  id_stall     out  1     hold PC and IF/ID register this cycle
//  ex_valid     out  1     EX holds a valid instruction
//  ex_pc        out  XLEN  latched PC
//  ex_a         out  XLEN  ALU operand A
//  ex_b         out  XLEN  ALU operand B (imm or rs2)
//  ex_sdata     out  XLEN  store data (rs2)
//  ex_rd        out  5     latched rd
//  ex_alu_op    out  OPW   latched ALU op
//  ex_wen       out  1     latched write enable, gated by valid
//  ex_store     out  1     latched store flag, gated by valid
//  ex_fwd       out  1     forwarding strobe: ex_valid & ex_wen & ex_rd!=0
//  ex_fwd_load  out  1     ex_valid & ex_load (forwarding unit ex_load)
//  bubble_cnt   out  CNT_W bubbles inserted for load-use, saturating
// BEHAVIOUR
//  - Reset: all registered outputs 0 (ex_valid=0, control flags 0, data 0,
//    bubble_cnt=0). Reset wins over every other input.
//  - Per-edge priority: p_reset > flush > ex_stall > load_hazard > advance.
//  - flush=1: ex_valid<=0, ex_wen/ex_load/ex_store<=0; data regs hold.
//    Flush overrides ex_stall and load_hazard; no bubble counted.
//  - ex_stall=1 (no flush): every EX register holds its value.
//  - load_hazard & id_valid (no flush/stall): bubble; ex_valid<=0, control
//    flags<=0, data hold; bubble_cnt += 1, holds at 2^CNT_W-1.
//  - Otherwise advance: all ex_* <= id_*; ex_valid<=id_valid;
//    ex_b <= id_use_imm ? id_imm : id_rs2_val; ex_sdata <= id_rs2_val.
//  - id_valid=0 on advance: bubble latched (ex_valid=0, flags 0); not counted.
//  - id_stall (combinational) = ~flush & (ex_stall | (load_hazard & id_valid)).
//  - ex_wen/ex_store/ex_fwd/ex_fwd_load are always 0 when ex_valid=0.
//  - ex_fwd, ex_fwd_load: combinational from registers only, no input paths.
//  - Latency: ID->EX exactly 1 cycle when unstalled. A load-use pair costs
//    exactly 1 bubble, because hazard drops once the load leaves EX.
//  - load_hazard while id_valid=0 is ignored (no stall, no count).
//  - Reset mid-stall: next cycle ex_valid=0, id_stall follows inputs only.
// TESTING
//  1 reset then id_valid=1,pc=0x100,rs1=5,rs2=7,use_imm=0,rd=3,wen=1 ->
//    next cycle ex_valid=1,ex_a=5,ex_b=7,ex_fwd=1; id_stall=0 throughout
//  2 load rd=4 in EX (ex_fwd_load=1), ID uses r4, load_hazard=1 -> id_stall=1
//    that cycle, next ex_valid=0,bubble_cnt=1; hazard low -> dependent enters
//  3 ex_stall=1 for 3 cycles with ID changing -> ex_* frozen, id_stall=1;
//    release -> newest ID instr latched next edge
//  4 flush=1 with load_hazard=1 and ex_stall=1 -> id_stall=0, next ex_valid=0,
//    ex_wen=0, bubble_cnt unchanged
//  5 rd=0,wen=1,valid -> ex_wen=1 but ex_fwd=0; use_imm=1,imm=0xFFFFFFF0 ->
//    ex_b=0xFFFFFFF0, ex_sdata=rs2
//  6 CNT_W=2, five load-use bubbles -> bubble_cnt 1,2,3,3,3; p_reset mid-run
//    -> all outputs 0 next cycle

Source files
------------

// File: rtl/p32_id_ex_stage.sv
// ID/EX pipeline register for the p32 pipeline: latches decoded ID instructions and
// forwarded operands into EX, turning load-use hazards into a single bubble.
module p32_id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int OPW   = 4,
  parameter int CNT_W = 16
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_val,
  input  logic [XLEN-1:0]  id_rs2_val,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_use_imm,
  input  logic [4:0]       id_rd,
  input  logic             id_wen,
  input  logic             id_load,
  input  logic             id_store,
  input  logic [OPW-1:0]   id_alu_op,
  input  logic             load_hazard,
  input  logic             ex_stall,
  input  logic             flush,
  output logic             id_stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_a,
  output logic [XLEN-1:0]  ex_b,
  output logic [XLEN-1:0]  ex_sdata,
  output logic [4:0]       ex_rd,
  output logic [OPW-1:0]   ex_alu_op,
  output logic             ex_wen,
  output logic             ex_store,
  output logic             ex_fwd,
  output logic             ex_fwd_load,
  output logic [CNT_W-1:0] bubble_cnt
);

  // Transfer semantics: ID hands an instruction to EX on a rising edge when
  // id_valid=1 and id_stall=0. While id_stall=1 the ID side must hold PC and
  // IF/ID unchanged; flush kills the transfer and never raises id_stall.
  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_HOLD    = 2'd2,
    ACT_FLUSH   = 2'd3
  } act_e;

  act_e             act;
  logic             hazard_live;

  logic             valid_q,  valid_d;
  logic [XLEN-1:0]  pc_q,     pc_d;
  logic [XLEN-1:0]  a_q,      a_d;
  logic [XLEN-1:0]  b_q,      b_d;
  logic [XLEN-1:0]  sdata_q,  sdata_d;
  logic [4:0]       rd_q,     rd_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic             wen_q,    wen_d;
  logic             load_q,   load_d;
  logic             store_q,  store_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  // A hazard only matters when there is a real consumer sitting in ID.
  assign hazard_live = load_hazard & id_valid;

  always_comb begin
    if (flush) begin
      act = ACT_FLUSH;
    end else if (ex_stall) begin
      act = ACT_HOLD;
    end else if (hazard_live) begin
      act = ACT_BUBBLE;
    end else begin
      act = ACT_ADVANCE;
    end
  end

  assign id_stall = ~flush & (ex_stall | hazard_live);

  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    a_d      = a_q;
    b_d      = b_q;
    sdata_d  = sdata_q;
    rd_d     = rd_q;
    alu_op_d = alu_op_q;
    wen_d    = wen_q;
    load_d   = load_q;
    store_d  = store_q;
    cnt_d    = cnt_q;
    case (act)
      ACT_FLUSH: begin
        valid_d = 1'b0;
        wen_d   = 1'b0;
        load_d  = 1'b0;
        store_d = 1'b0;
      end
      ACT_HOLD: begin
        valid_d = valid_q;
      end
      ACT_BUBBLE: begin
        valid_d = 1'b0;
        wen_d   = 1'b0;
        load_d  = 1'b0;
        store_d = 1'b0;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // Data fields follow ID even for an empty slot; control flags never do.
        valid_d  = id_valid;
        pc_d     = id_pc;
        a_d      = id_rs1_val;
        b_d      = id_use_imm ? id_imm : id_rs2_val;
        sdata_d  = id_rs2_val;
        rd_d     = id_rd;
        alu_op_d = id_alu_op;
        wen_d    = id_wen   & id_valid;
        load_d   = id_load  & id_valid;
        store_d  = id_store & id_valid;
      end
    endcase
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sdata_q  <= '0;
      rd_q     <= '0;
      alu_op_q <= '0;
      wen_q    <= 1'b0;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sdata_q  <= sdata_d;
      rd_q     <= rd_d;
      alu_op_q <= alu_op_d;
      wen_q    <= wen_d;
      load_q   <= load_d;
      store_q  <= store_d;
      cnt_q    <= cnt_d;
    end
  end

  // Flags are re-gated by valid so a stale flag can never escape an empty slot.
  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_a        = a_q;
  assign ex_b        = b_q;
  assign ex_sdata    = sdata_q;
  assign ex_rd       = rd_q;
  assign ex_alu_op   = alu_op_q;
  assign ex_wen      = valid_q & wen_q;
  assign ex_store    = valid_q & store_q;
  assign ex_fwd      = valid_q & wen_q & (rd_q != 5'd0);
  assign ex_fwd_load = valid_q & load_q;
  assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_p32_id_ex_stage.sv
// Bench for p32_id_ex_stage: directed vector table with hand-derived expectations,
// followed by random cycles, all checked through a scoreboard of expected EX state.
module tb_p32_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int OPW   = 4;
  localparam int CNT_W = 2;

  typedef struct {
    logic             rst;
    logic             v;
    logic [XLEN-1:0]  pc, rs1, rs2, imm;
    logic             ui;
    logic [4:0]       rd;
    logic             wen, ld, st;
    logic [OPW-1:0]   op;
    logic             hz, es, fl;
    logic             e_stall;
    logic             e_valid;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc, a, b, sdata;
    logic [4:0]       rd;
    logic [OPW-1:0]   op;
    logic             wen, ld, st;
    logic [CNT_W-1:0] cnt;
  } mdl_t;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc, a, b, sdata;
    logic [4:0]       rd;
    logic [OPW-1:0]   op;
    logic             wen, st, fwd, fwd_load;
    logic [CNT_W-1:0] cnt;
  } ex_t;

  localparam int EXW = $bits(ex_t);

  logic             clk = 1'b0;
  logic             p_reset, id_valid, id_use_imm, id_wen, id_load, id_store;
  logic [XLEN-1:0]  id_pc, id_rs1_val, id_rs2_val, id_imm;
  logic [4:0]       id_rd;
  logic [OPW-1:0]   id_alu_op;
  logic             load_hazard, ex_stall, flush;
  logic             id_stall, ex_valid, ex_wen, ex_store, ex_fwd, ex_fwd_load;
  logic [XLEN-1:0]  ex_pc, ex_a, ex_b, ex_sdata;
  logic [4:0]       ex_rd;
  logic [OPW-1:0]   ex_alu_op;
  logic [CNT_W-1:0] bubble_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  vec_t           vecs[$];
  logic [EXW-1:0] exp_q[$];
  mdl_t           mdl;

  always #5 clk = ~clk;

  p32_id_ex_stage #(.XLEN(XLEN), .OPW(OPW), .CNT_W(CNT_W)) dut (
    .m_clock(clk), .p_reset(p_reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_rd(id_rd), .id_wen(id_wen), .id_load(id_load),
    .id_store(id_store), .id_alu_op(id_alu_op), .load_hazard(load_hazard),
    .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b), .ex_sdata(ex_sdata), .ex_rd(ex_rd),
    .ex_alu_op(ex_alu_op), .ex_wen(ex_wen), .ex_store(ex_store), .ex_fwd(ex_fwd),
    .ex_fwd_load(ex_fwd_load), .bubble_cnt(bubble_cnt)
  );

  task automatic add(input logic rst, input logic v, input logic [XLEN-1:0] pc,
                     input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                     input logic [XLEN-1:0] imm, input logic ui, input logic [4:0] rd,
                     input logic wen, input logic ld, input logic st,
                     input logic [OPW-1:0] op, input logic hz, input logic es,
                     input logic fl, input logic e_stall, input logic e_valid,
                     input logic [CNT_W-1:0] e_cnt);
    vec_t r;
    r.rst = rst; r.v = v; r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
    r.ui = ui; r.rd = rd; r.wen = wen; r.ld = ld; r.st = st; r.op = op;
    r.hz = hz; r.es = es; r.fl = fl;
    r.e_stall = e_stall; r.e_valid = e_valid; r.e_cnt = e_cnt;
    vecs.push_back(r);
  endtask

  function automatic mdl_t mdl_next(input mdl_t m, input vec_t r);
    mdl_t n = m;
    if (r.rst) begin
      n = '0;
    end else if (r.fl) begin
      n.valid = 1'b0; n.wen = 1'b0; n.ld = 1'b0; n.st = 1'b0;
    end else if (r.es) begin
      n = m;
    end else if (r.hz && r.v) begin
      n.valid = 1'b0; n.wen = 1'b0; n.ld = 1'b0; n.st = 1'b0;
      if (m.cnt != {CNT_W{1'b1}}) n.cnt = m.cnt + 1'b1;
    end else begin
      n.valid = r.v; n.pc = r.pc; n.a = r.rs1; n.sdata = r.rs2;
      n.b  = r.ui ? r.imm : r.rs2;
      n.rd = r.rd; n.op = r.op;
      n.wen = r.v & r.wen; n.ld = r.v & r.ld; n.st = r.v & r.st;
    end
    return n;
  endfunction

  function automatic ex_t to_ex(input mdl_t m);
    ex_t e;
    e.valid = m.valid; e.pc = m.pc; e.a = m.a; e.b = m.b; e.sdata = m.sdata;
    e.rd = m.rd; e.op = m.op;
    e.wen = m.valid & m.wen;
    e.st  = m.valid & m.st;
    e.fwd = m.valid & m.wen & (m.rd != 5'd0);
    e.fwd_load = m.valid & m.ld;
    e.cnt = m.cnt;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t r, input bit use_tbl, input int idx);
    ex_t act, exp;
    @(negedge clk);
    p_reset = r.rst; id_valid = r.v; id_pc = r.pc; id_rs1_val = r.rs1;
    id_rs2_val = r.rs2; id_imm = r.imm; id_use_imm = r.ui; id_rd = r.rd;
    id_wen = r.wen; id_load = r.ld; id_store = r.st; id_alu_op = r.op;
    load_hazard = r.hz; ex_stall = r.es; flush = r.fl;
    #1;
    check($sformatf("id_stall[%0d]", idx), {31'd0, id_stall}, {31'd0, r.e_stall});
    mdl = mdl_next(mdl, r);
    exp_q.push_back(to_ex(mdl));
    @(posedge clk);
    #1;
    act.valid = ex_valid; act.pc = ex_pc; act.a = ex_a; act.b = ex_b;
    act.sdata = ex_sdata; act.rd = ex_rd; act.op = ex_alu_op; act.wen = ex_wen;
    act.st = ex_store; act.fwd = ex_fwd; act.fwd_load = ex_fwd_load;
    act.cnt = bubble_cnt;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL ex_state[%0d]: scoreboard empty, got %h", idx, act);
    end else begin
      exp = ex_t'(exp_q.pop_front());
      if (act !== exp) begin
        tests_failed++;
        $display("FAIL ex_state[%0d]: got %h expected %h", idx, act, exp);
      end
    end
    if (use_tbl) begin
      check($sformatf("ex_valid[%0d]", idx), {31'd0, ex_valid}, {31'd0, r.e_valid});
      check($sformatf("bubble_cnt[%0d]", idx), 32'(bubble_cnt), 32'(r.e_cnt));
    end
  endtask

  initial begin
    vec_t r;
    mdl = '0;
    // rst v  pc      rs1    rs2      imm          ui rd wen ld st op  hz es fl  stall valid cnt
    add(1, 0, 0,      0,     0,       0,           0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
    add(0, 1, 'h100,  5,     7,       0,           0, 3,  1, 0, 0, 2,  0, 0, 0,  0, 1, 0);
    add(0, 1, 'h104,  8,     0,       4,           1, 4,  1, 1, 0, 0,  0, 0, 0,  0, 1, 0);
    add(0, 1, 'h108,  'h11,  9,       0,           0, 5,  1, 0, 0, 1,  1, 0, 0,  1, 0, 1);
    add(0, 1, 'h108,  'h55,  9,       0,           0, 5,  1, 0, 0, 1,  0, 0, 0,  0, 1, 1);
    add(0, 1, 'h10c,  1,     2,       0,           0, 6,  1, 0, 0, 3,  0, 1, 0,  1, 1, 1);
    add(0, 1, 'h110,  3,     4,       0,           0, 7,  1, 0, 0, 4,  0, 1, 0,  1, 1, 1);
    add(0, 1, 'h114,  5,     6,       0,           0, 8,  1, 0, 0, 5,  0, 1, 0,  1, 1, 1);
    add(0, 1, 'h118,  9,     10,      0,           0, 9,  1, 0, 0, 6,  0, 0, 0,  0, 1, 1);
    add(0, 1, 'h11c,  1,     1,       0,           0, 10, 1, 1, 0, 0,  1, 1, 1,  0, 0, 1);
    add(0, 1, 'h120,  'h33,  'h1234,  'hFFFFFFF0,  1, 0,  1, 0, 1, 7,  0, 0, 0,  0, 1, 1);
    add(0, 0, 'h124,  0,     0,       0,           0, 2,  1, 0, 0, 0,  1, 0, 0,  0, 0, 1);
    add(1, 0, 0,      0,     0,       0,           0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
    add(0, 1, 'h200,  1,     2,       0,           0, 6,  1, 0, 0, 1,  1, 0, 0,  1, 0, 1);
    add(0, 1, 'h204,  1,     2,       0,           0, 6,  1, 0, 0, 1,  1, 0, 0,  1, 0, 2);
    add(0, 1, 'h208,  1,     2,       0,           0, 6,  1, 0, 0, 1,  1, 0, 0,  1, 0, 3);
    add(0, 1, 'h20c,  1,     2,       0,           0, 6,  1, 0, 0, 1,  1, 0, 0,  1, 0, 3);
    add(0, 1, 'h210,  1,     2,       0,           0, 6,  1, 0, 0, 1,  1, 0, 0,  1, 0, 3);
    add(0, 1, 'h300,  4,     5,       0,           0, 12, 1, 0, 0, 2,  0, 1, 0,  1, 0, 3);
    add(1, 1, 'h304,  4,     5,       0,           0, 12, 1, 1, 0, 2,  1, 1, 0,  1, 0, 0);
    add(0, 1, 'h308,  2,     3,       0,           0, 11, 1, 0, 1, 8,  0, 0, 0,  0, 1, 0);

    foreach (vecs[i]) step(vecs[i], 1'b1, i);

    for (int i = 0; i < 300; i++) begin
      r.rst = ($urandom_range(0, 39) == 0);
      r.v   = ($urandom_range(0, 3) != 0);
      r.pc  = $urandom; r.rs1 = $urandom; r.rs2 = $urandom; r.imm = $urandom;
      r.ui  = 1'($urandom_range(0, 1));
      r.rd  = 5'($urandom_range(0, 31));
      r.wen = 1'($urandom_range(0, 1));
      r.ld  = 1'($urandom_range(0, 1));
      r.st  = 1'($urandom_range(0, 1));
      r.op  = OPW'($urandom_range(0, 15));
      r.hz  = ($urandom_range(0, 3) == 0);
      r.es  = ($urandom_range(0, 3) == 0);
      r.fl  = ($urandom_range(0, 7) == 0);
      r.e_stall = ~r.fl & (r.es | (r.hz & r.v));
      r.e_valid = 1'b0;
      r.e_cnt   = '0;
      step(r, 1'b0, 1000 + i);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
